// File: rtl/ethsubsys_fifo_pkg.sv
// -----------------------------------------------------------------------------
// ethsubsys_fifo_pkg
// Shared constants and helpers for the ethsubsystem FIFO family
// (eth_sync_fifo_2psram and its read-side adapters).
//   RD_LAT_MIN / RD_LAT_MAX : legal range of the FIFO read latency
//   log2b(value)            : number of bits needed to hold 'value' (min 1)
// -----------------------------------------------------------------------------
package ethsubsys_fifo_pkg;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 2;

    // Width needed to represent 'value' itself (not value-1), so a counter
    // sized with log2b(N) can hold the full-occupancy value N.
    function automatic int unsigned log2b(input int unsigned value);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((value >> i) != 0) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/eth_skid_ram.sv
// -----------------------------------------------------------------------------
// eth_skid_ram
// DEPTH x DATA_WIDTH register array used as the skid buffer of the FIFO read
// adapter. Synchronous write at wr_ptr_i, asynchronous read at rd_ptr_i.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset (clears all entries)
//   wr_en_i        : write strobe
//   wr_ptr_i       : write address
//   wr_data_i      : write data
//   rd_ptr_i       : read address
//   rd_data_o      : read data (combinational from the array)
// -----------------------------------------------------------------------------
module eth_skid_ram #(
    parameter int unsigned DATA_WIDTH = 289,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned PTR_W      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en_i,
    input  logic [PTR_W-1:0]      wr_ptr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [PTR_W-1:0]      rd_ptr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_ptr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/eth_fifo_stream_rdport.sv
// -----------------------------------------------------------------------------
// eth_fifo_stream_rdport
// Read-side adapter for eth_sync_fifo_2psram: turns the FIFO's standard-read
// interface (rd_en, dout READ_LATENCY cycles later, empty) into a
// first-word-fall-through valid/ready stream. Reads are prefetched into a
// READ_LATENCY+2 entry skid buffer so streaming runs at one word per cycle.
// fifo_rd_en never depends on m_ready.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   fifo_rd_en  : read strobe to the FIFO
//   fifo_dout   : FIFO read data, valid READ_LATENCY cycles after fifo_rd_en
//   fifo_empty  : FIFO empty flag
//   flush       : synchronous flush of buffered and in-flight words
//   m_valid     : stream word valid
//   m_data      : stream word (held while m_valid && !m_ready)
//   m_ready     : downstream accept
//   buf_count   : words currently held in the skid buffer
// -----------------------------------------------------------------------------
module eth_fifo_stream_rdport
    import ethsubsys_fifo_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH   = 289,
    parameter  int unsigned READ_LATENCY = 1,
    localparam int unsigned BUF_DEPTH    = READ_LATENCY + 2,
    localparam int unsigned CNT_WIDTH    = log2b(BUF_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    input  logic                  flush,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  buf_count
);

    localparam int unsigned PTR_W  = log2b(BUF_DEPTH - 1);
    localparam int unsigned INFL_W = log2b(READ_LATENCY);

    if ((READ_LATENCY < RD_LAT_MIN) || (READ_LATENCY > RD_LAT_MAX)) begin : g_bad_latency
        $error("eth_fifo_stream_rdport: READ_LATENCY must be 1 or 2");
    end

    logic                    active_q;
    logic [CNT_WIDTH-1:0]    occ_q, occ_d;
    logic [INFL_W-1:0]       infl_q, infl_d;
    logic [READ_LATENCY-1:0] rvld_q, rvld_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic                    room;
    logic                    issue;
    logic                    ret;
    logic                    pop;

    // BUF_DEPTH is not a power of two, so the wrap is explicit.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Counting in-flight reads against the free space guarantees every
    // returning word has a slot, without looking at m_ready. active_q keeps
    // the strobe low while rst_n is asserted.
    assign room       = (int'(occ_q) + int'(infl_q)) < int'(BUF_DEPTH);
    assign issue      = active_q && !fifo_empty && !flush && room;
    assign fifo_rd_en = issue;

    // A return landing during flush belongs to a discarded read.
    assign ret       = rvld_q[READ_LATENCY-1] && !flush;
    assign m_valid   = (occ_q != '0);
    assign pop       = m_valid && m_ready;
    assign buf_count = occ_q;

    always_comb begin
        occ_d    = occ_q;
        infl_d   = infl_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rvld_d   = READ_LATENCY'({rvld_q, issue});

        if (flush) begin
            occ_d    = '0;
            infl_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            rvld_d   = '0;
        end else begin
            unique case ({ret, pop})
                2'b10:   occ_d = occ_q + CNT_WIDTH'(1);
                2'b01:   occ_d = occ_q - CNT_WIDTH'(1);
                default: occ_d = occ_q;
            endcase
            unique case ({issue, ret})
                2'b10:   infl_d = infl_q + INFL_W'(1);
                2'b01:   infl_d = infl_q - INFL_W'(1);
                default: infl_d = infl_q;
            endcase
            if (ret) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            occ_q    <= '0;
            infl_q   <= '0;
            rvld_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            active_q <= 1'b1;
            occ_q    <= occ_d;
            infl_q   <= infl_d;
            rvld_q   <= rvld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    eth_skid_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH),
        .PTR_W      (PTR_W)
    ) u_skid_ram (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .wr_en_i   (ret),
        .wr_ptr_i  (wr_ptr_q),
        .wr_data_i (fifo_dout),
        .rd_ptr_i  (rd_ptr_q),
        .rd_data_o (m_data)
    );

`ifndef SYNTHESIS
    // A return into a full buffer means the issue accounting is broken.
    always @(posedge clk) begin
        if (rst_n && ret) begin
            assert (occ_q < CNT_WIDTH'(BUF_DEPTH))
            else $error("eth_fifo_stream_rdport: skid buffer overflow");
        end
    end
`endif

endmodule
